seq_mult_unit: RTL and testbench
================================

Name: seq_mult_unit

Overview:
- Multi-cycle 32x32 -> 64-bit multiplier for the MIPS MULT/MULTU path. It writes the HI and LO results.
- Sits downstream of the decode/register-read stage and drives the operands of a 32-bit ripple-carry adder with carry-out, using a shift-add loop.
- The adder's sum and carry-out are consumed every iteration.
- Exposes a start/busy/done handshake so the pipeline stalls MFHI/MFLO until the result is ready.

Parameters:
WIDTH, 32, operand width; only 32 is supported and the product is 2*WIDTH.
CNT_W, 5, iteration counter width, equal to clog2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU
a  input  32  multiplicand, sampled with start
b  input  32  multiplier, sampled with start
busy  output  1  high from the cycle after accept until done
done  output  1  single-cycle pulse; hi/lo are valid in that cycle
hi  output  32  product[63:32], held until the next done
lo  output  32  product[31:0], held until the next done

Behaviour:
- Reset: one clock, synchronous, active-high.
  - rst=1 at a rising edge gives state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - rst has priority over everything, including mid-CALC; any partial product is discarded.
- States: IDLE, CALC, FIX.
  - IDLE: busy=0. start=1 at edge E0 captures operands:
    - mcand = |a| if is_signed, else a; mplier = |b| likewise.
    - neg = is_signed & (a[31]^b[31]).
    - acc (33 bits) = 0; counter = 31; next state = CALC.
  - CALC: busy=1. Each edge:
    - addend = mplier_reg[0] ? mcand : 0.
    - {cout,sum} = acc[31:0] + addend through the 32-bit adder, carry-in 0.
    - {acc, mplier_reg} shifts right one bit, so the new value is {cout, sum, mplier_reg[31:1]} with the top bit cleared.
    - counter decrements; when counter==0, the next state is FIX.
    - There are exactly 32 CALC edges.
  - FIX: busy=1.
    - At the edge: product = neg ? (~P + 1) over 64 bits : P, where P = {acc[31:0], mplier_reg}.
    - hi/lo are loaded, done is set for one cycle, and the next state is IDLE.
- Latency:
  - start accepted at E0; done=1 in the cycle following E33.
  - busy=1 from after E0 through the cycle after E32, then 0 while done=1.
  - Back-to-back start is allowed in the cycle done=1, because the state is IDLE then.
- start while busy: ignored, with no effect on operands or state.
- start held high continuously: a new operation is accepted in each IDLE cycle.
- Magnitude rule: |x| = ~x+1 for x[31]=1. 0x80000000 maps to 0x80000000, which is correct as an unsigned magnitude.
- Width rules:
  - The adder carry-out must be kept (33-bit acc), otherwise high products are lost.
  - The negation carry propagates across all 64 bits.
- Zero operands: no early termination; latency stays fixed at 33 cycles.
- is_signed=0 with a[31]=1: treated as a large unsigned value, never negated.

Decomposition:
- Shared package mips_pkg holds:
  - the FSM state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2);
  - the WIDTH constant;
  - the funct codes for MULT/MULTU (6'h18 / 6'h19) used by decode to generate start/is_signed.
- One sub-module is natural: the 32-bit ripple-carry adder with carry-in/carry-out, instantiated once for the iteration add.
- The 64-bit final negation stays inline.

Test Plan:
- Reset mid-CALC: start a=7, b=9, assert rst at cycle 10 -> busy=0, done never pulses, hi=lo=0. A new start then gives done at +33 with lo=63.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done after 33 cycles, hi=0xFFFFFFFE, lo=0x00000001 (checks carry-out use).
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. MULTU with the same operands gives the same values.
- Start pulsed again at cycle 5 of CALC with a=2, b=2 -> ignored; result of the original a=6, b=7 gives lo=42, hi=0, still at cycle 33.
- Back-to-back: a second start (a=0, b=0x1234, signed) issued in the done cycle -> second done exactly 33 cycles later, hi=lo=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiplier FSM encoding, datapath width and the
// MULT/MULTU funct codes that decode uses to raise start/is_signed.
package mips_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/seq_mult_unit_adder.sv
// Ripple-carry adder with carry-in and carry-out; the multiplier uses it
// once per shift-add iteration.
module seq_mult_unit_adder #(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_mult_unit.sv
// Multi-cycle 32x32 -> 64 shift-add multiplier for MULT/MULTU. Operands are
// multiplied as magnitudes and the sign is applied in the final FIX cycle.
module seq_mult_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [WIDTH-1:0] acc_p0;
  logic             neg_p0;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] product;

  // Two's complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic                    en);
    if (en && x[WIDTH-1])
      return ~x + 1'b1;
    return x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic               neg);
    if (neg)
      return ~p + 1'b1;
    return p;
  endfunction

  assign addend  = mplier_p0[0] ? mcand_p0 : '0;
  assign product = apply_sign({acc_p0, mplier_p0}, neg_p0);
  assign busy    = (state != IDLE);

  seq_mult_unit_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_p0),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control path: state, counter and the visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) cnt <= CNT_W'(WIDTH - 1);
        CALC: cnt <= cnt - 1'b1;
        FIX: begin
          hi   <= product[2*WIDTH-1:WIDTH];
          lo   <= product[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath: the shifted {cout, sum} keeps the adder carry in acc bit 31,
  // so the 33rd accumulator bit is always zero and is not stored.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        mcand_p0  <= magnitude(a, is_signed);
        mplier_p0 <= magnitude(b, is_signed);
        neg_p0    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_p0    <= '0;
      end
      CALC: begin
        acc_p0    <= {cout, sum[WIDTH-1:1]};
        mplier_p0 <= {sum[0], mplier_p0[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: vector table, handshake corner sequences and
// randomized operands against a plain 64-bit arithmetic product.
module tb_seq_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_pass = 0;

  seq_mult_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  // Called at a falling edge; the operation is accepted at the next rising edge.
  task automatic issue(input bit s, input logic [31:0] x, input logic [31:0] y);
    start     = 1'b1;
    is_signed = s;
    a         = x;
    b         = y;
  endtask

  // Returns at the falling edge where done is seen; lat counts rising edges
  // after the accepting edge (expected 33). Optionally pulses start at cycle inj.
  task automatic wait_done(input int inj, input logic [31:0] ia, input logic [31:0] ib,
                           output int lat, output logic b32, output logic bdone);
    lat   = -1;
    b32   = 1'b0;
    bdone = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 32) b32 = busy;
      if (done) begin
        lat   = c;
        bdone = busy;
        break;
      end
      if (c == inj) begin
        start = 1'b1;
        a     = ia;
        b     = ib;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int          lat;
    logic        b32, bdone;
    int          pulses;
    bit          s;
    logic [31:0] x, y;
    logic [63:0] p;

    vecs[0] = '{"multu_ff_ff",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_m3_5",    1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{"mult_min_min", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{"multu_min_min",1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{"multu_big_a",  1'b0, 32'h80000001, 32'h00000002, 32'h00000001, 32'h00000002};
    vecs[5] = '{"mult_m1_m1",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[6] = '{"mult_max_min", 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[7] = '{"mult_zero",    1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done(0, '0, '0, lat, b32, bdone);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'd33);
      chk({vecs[i].name, "_hi"},  64'(hi),  64'(vecs[i].hi));
      chk({vecs[i].name, "_lo"},  64'(lo),  64'(vecs[i].lo));
      if (i == 0) begin
        chk("busy_cycle32", 64'(b32),   64'd1);
        chk("busy_at_done", 64'(bdone), 64'd0);
      end
    end

    // Start re-pulsed mid-CALC is ignored; then a back-to-back start in the done cycle.
    issue(1'b1, 32'd6, 32'd7);
    wait_done(5, 32'd2, 32'd2, lat, b32, bdone);
    chk("ignored_lat", 64'(lat), 64'd33);
    chk("ignored_hi",  64'(hi),  64'd0);
    chk("ignored_lo",  64'(lo),  64'd42);
    issue(1'b1, 32'd0, 32'h1234);
    wait_done(0, '0, '0, lat, b32, bdone);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_hi",  64'(hi),  64'd0);
    chk("b2b_lo",  64'(lo),  64'd0);

    // Put a nonzero result in hi/lo, then reset in the middle of CALC.
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, '0, '0, lat, b32, bdone);
    issue(1'b0, 32'd7, 32'd9);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi",   64'(hi),   64'd0);
    chk("midrst_lo",   64'(lo),   64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    issue(1'b0, 32'd7, 32'd9);
    wait_done(0, '0, '0, lat, b32, bdone);
    chk("after_rst_lat", 64'(lat), 64'd33);
    chk("after_rst_lo",  64'(lo),  64'd63);
    chk("after_rst_hi",  64'(hi),  64'd0);

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      if (i % 6 == 0) x = 32'h80000000;
      if (i % 7 == 0) y = 32'hFFFFFFFF;
      p = ref_prod(s, x, y);
      issue(s, x, y);
      wait_done(0, '0, '0, lat, b32, bdone);
      chk($sformatf("rand%0d_lat", i), 64'(lat), 64'd33);
      chk($sformatf("rand%0d_hi", i),  64'(hi),  64'(p[63:32]));
      chk($sformatf("rand%0d_lo", i),  64'(lo),  64'(p[31:0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
